// File: rtl/mvm_sched_ctrl_if.sv
// Handshake and datapath-control bundle between mvm_sched_ctrl (slave) and its environment (master).
// Both streams use the same valid/ready rule: a word moves on a cycle where valid && ready are both high.
interface mvm_sched_ctrl_if #(
  parameter int VEC_W = 2,
  parameter int MAT_W = 4
) ();
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [MAT_W-1:0] addr_a;
  logic             wr_en_a;
  logic [VEC_W-1:0] addr_x;
  logic             wr_en_x;
  logic [VEC_W-1:0] addr_y;
  logic             wr_en_y;
  logic             mac_en;
  logic             clear_acc;
  logic             busy;
  logic             done;

  modport master (
    output start, in_valid, out_ready,
    input  in_ready, out_valid, addr_a, wr_en_a, addr_x, wr_en_x,
           addr_y, wr_en_y, mac_en, clear_acc, busy, done
  );

  modport slave (
    input  start, in_valid, out_ready,
    output in_ready, out_valid, addr_a, wr_en_a, addr_x, wr_en_x,
           addr_y, wr_en_y, mac_en, clear_acc, busy, done
  );
endinterface

// File: rtl/mvm_sched_ctrl.sv
// Sequencer for the matrix-vector multiply datapath: loads A and x, issues N*N products, drains, streams y.
// Optional MVM_CYCLE_COUNT_EN adds a saturating 32-bit cyc_count of non-IDLE cycles.
module mvm_sched_ctrl #(
  parameter int MAT_SCALE        = 3,
  parameter int VEC_MEM_SIZE_LOG = $clog2(MAT_SCALE),
  parameter int MAT_MEM_SIZE_LOG = $clog2(MAT_SCALE*MAT_SCALE)
) (
  input  logic       clk,
  input  logic       reset,
  mvm_sched_ctrl_if.slave bus,
  output logic [2:0] dbg_state_o
`ifdef MVM_CYCLE_COUNT_EN
  ,
  output logic [31:0] cyc_count
`endif
);
  localparam int VW = VEC_MEM_SIZE_LOG;
  localparam int MW = MAT_MEM_SIZE_LOG;
  localparam logic [MW-1:0] N_A    = MW'(MAT_SCALE);
  localparam logic [MW-1:0] LAST_A = MW'(MAT_SCALE*MAT_SCALE - 1);
  localparam logic [VW-1:0] LAST_V = VW'(MAT_SCALE - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_X  = 3'd2,
    COMPUTE = 3'd3,
    DRAIN   = 3'd4,
    OUTPUT  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [MW-1:0] cnt_q, cnt_d;
  logic [VW-1:0] i_q, i_d;
  logic [VW-1:0] j_q, j_d;
  logic [VW-1:0] k_q, k_d;
  logic          drain_q, drain_d;
  logic          done_q, done_d;

  // Issue-stage strobes feeding the two-deep control pipeline.
  logic          issue;
  logic          mac_q, clr_q;
  logic          wy1_q, wy2_q;
  logic [VW-1:0] row1_q, row2_q;

  logic          in_ready, out_valid, wr_en_a, wr_en_x;
  logic [MW-1:0] addr_a;
  logic [VW-1:0] addr_x;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      drain_q <= 1'b0;
      done_q  <= 1'b0;
      mac_q   <= 1'b0;
      clr_q   <= 1'b0;
      wy1_q   <= 1'b0;
      wy2_q   <= 1'b0;
      row1_q  <= '0;
      row2_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      drain_q <= drain_d;
      done_q  <= done_d;
      mac_q   <= issue;
      clr_q   <= issue && (j_q == '0);
      wy1_q   <= issue && (j_q == LAST_V);
      row1_q  <= i_q;
      wy2_q   <= wy1_q;
      row2_q  <= row1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    drain_d   = drain_q;
    done_d    = 1'b0;
    issue     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    wr_en_a   = 1'b0;
    wr_en_x   = 1'b0;
    addr_a    = '0;
    addr_x    = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD_A;
          cnt_d   = '0;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      LOAD_A: begin
        in_ready = 1'b1;
        addr_a   = cnt_q;
        wr_en_a  = bus.in_valid;
        if (bus.in_valid) begin
          if (cnt_q == LAST_A) begin
            cnt_d   = '0;
            state_d = LOAD_X;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LOAD_X: begin
        in_ready = 1'b1;
        addr_x   = cnt_q[VW-1:0];
        wr_en_x  = bus.in_valid;
        if (bus.in_valid) begin
          if (cnt_q[VW-1:0] == LAST_V) begin
            cnt_d   = '0;
            state_d = COMPUTE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      COMPUTE: begin
        issue  = 1'b1;
        addr_a = MW'(i_q) * N_A + MW'(j_q);
        addr_x = j_q;
        if (j_q == LAST_V) begin
          j_d = '0;
          if (i_q == LAST_V) begin
            i_d     = '0;
            drain_d = 1'b0;
            state_d = DRAIN;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q) begin
          k_d     = '0;
          state_d = OUTPUT;
        end else begin
          drain_d = 1'b1;
        end
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          if (k_q == LAST_V) begin
            k_d     = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.addr_a    = addr_a;
  assign bus.wr_en_a   = wr_en_a;
  assign bus.addr_x    = addr_x;
  assign bus.wr_en_x   = wr_en_x;
  assign bus.mac_en    = mac_q;
  assign bus.clear_acc = clr_q;
  assign bus.wr_en_y   = wy2_q;
  // y address serves the read-out counter in OUTPUT and the row write-back otherwise.
  assign bus.addr_y    = (state_q == OUTPUT) ? k_q : (wy2_q ? row2_q : '0);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign dbg_state_o   = state_q;

`ifdef MVM_CYCLE_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_count <= '0;
    end else if (state_q == IDLE) begin
      if (bus.start) cyc_count <= '0;
    end else if (cyc_count != '1) begin
      cyc_count <= cyc_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mvm_sched_ctrl.sv
// Randomized bench for mvm_sched_ctrl: drives the streams, models the external datapath,
// and compares y and control timing against a matrix-vector reference.
module tb_mvm_sched_ctrl;
  localparam int N  = 3;
  localparam int NN = N * N;

  logic clk;
  logic reset;
  logic [2:0] dbg_state;
  logic [7:0] data_in;
`ifdef MVM_CYCLE_COUNT_EN
  logic [31:0] cyc_count;
`endif

  int n_checks;
  int n_errors;
  int done_cnt;

  logic signed [7:0]  a_v [NN];
  logic signed [7:0]  x_v [N];
  logic        [15:0] y_exp [N];

  logic signed [7:0]  a_mem [16];
  logic signed [7:0]  x_mem [4];
  logic signed [15:0] prod_q;
  logic signed [15:0] acc_q;
  logic        [15:0] y_mem [4];
  logic        [15:0] data_out;

  mvm_sched_ctrl_if #(.VEC_W(2), .MAT_W(4)) bus ();

  mvm_sched_ctrl #(.MAT_SCALE(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
`ifdef MVM_CYCLE_COUNT_EN
    ,
    .cyc_count   (cyc_count)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external datapath: async-read memories, product register, accumulator, y memory
  always @(posedge clk) begin
    if (bus.wr_en_a) a_mem[bus.addr_a] <= data_in;
    if (bus.wr_en_x) x_mem[bus.addr_x] <= data_in;
    prod_q <= a_mem[bus.addr_a] * x_mem[bus.addr_x];
    if (bus.mac_en) acc_q <= bus.clear_acc ? prod_q : acc_q + prod_q;
    if (bus.wr_en_y) y_mem[bus.addr_y] <= acc_q;
  end
  assign data_out = y_mem[bus.addr_y];

  always @(negedge clk) if (bus.done) done_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq(tag, {15'd0, bus.busy, bus.done, bus.in_ready, bus.out_valid, bus.wr_en_a,
                   bus.wr_en_x, bus.wr_en_y, bus.mac_en, bus.clear_acc,
                   bus.addr_a, bus.addr_x, bus.addr_y}, 32'd0);
  endtask

  function automatic void build_ref();
    for (int r = 0; r < N; r++) begin
      int s;
      s = 0;
      for (int c = 0; c < N; c++) s += int'(a_v[r*N+c]) * int'(x_v[c]);
      y_exp[r] = s[15:0];
    end
  endfunction

  // in_mode: 0 continuous, 1 alternate bubbles, 2 random; out_mode: 0 stall table, 1 random
  task automatic run_op(input int in_mode, input int out_mode, input int stall_k,
                        input int stall_len, input bit glitch, input int reset_at);
    int lc, acc_n, wa, wx, rel, k_exp, stall_left, mac_n, clr_n, wy_n, d0;
    bit iv, seen_ov, aborted;
    build_ref();
    d0 = done_cnt;
    lc = 0; acc_n = 0; wa = 0; wx = 0;
    check_eq("idle_busy", bus.busy, 0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (acc_n < NN + N && lc < 200) begin
      if (in_mode == 0)      iv = 1'b1;
      else if (in_mode == 1) iv = (lc % 2 == 0);
      else                   iv = 1'($urandom_range(0, 1));
      bus.in_valid = iv;
      data_in = (acc_n < NN) ? a_v[acc_n] : x_v[(acc_n < NN + N) ? acc_n - NN : 0];
      bus.start = glitch && (acc_n >= NN);
      @(negedge clk);
      check_eq("load_in_ready", bus.in_ready, 1);
      if (acc_n < NN) begin
        check_eq("addr_a", bus.addr_a, acc_n);
        check_eq("wr_en_a", bus.wr_en_a, iv);
        check_eq("wr_en_x_off", bus.wr_en_x, 0);
      end else begin
        check_eq("addr_x", bus.addr_x, acc_n - NN);
        check_eq("wr_en_x", bus.wr_en_x, iv);
        check_eq("wr_en_a_off", bus.wr_en_a, 0);
      end
      wa += int'(bus.wr_en_a);
      wx += int'(bus.wr_en_x);
      if (iv) acc_n++;
      lc++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    check_eq("a_writes", wa, NN);
    check_eq("x_writes", wx, N);
    if (in_mode == 1) check_eq("load_span", lc, 2 * (NN + N) - 1);

    rel = 0; k_exp = 0; stall_left = stall_len; mac_n = 0; clr_n = 0; wy_n = 0;
    seen_ov = 1'b0; aborted = 1'b0;
    while (k_exp < N && rel < 200 && !aborted) begin
      if (rel == reset_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle("rst_mid");
`ifdef MVM_CYCLE_COUNT_EN
        check_eq("rst_cyc", cyc_count, 0);
`endif
        aborted = 1'b1;
      end else begin
        if (out_mode == 1) bus.out_ready = 1'($urandom_range(0, 1));
        else               bus.out_ready = !(k_exp == stall_k && stall_left > 0);
        bus.start = glitch && seen_ov;
        @(negedge clk);
        if (seen_ov || bus.out_valid) begin
          if (!seen_ov) check_eq("first_ov_cyc", rel, NN + 2);
          seen_ov = 1'b1;
          check_eq("ov_hold", bus.out_valid, 1);
          check_eq("out_addr_y", bus.addr_y, k_exp);
          check_eq("no_early_done", bus.done, 0);
          if (bus.out_ready) begin
            check_eq("y", data_out, y_exp[k_exp]);
            k_exp++;
          end else begin
            stall_left--;
          end
        end else begin
          check_eq("cmp_in_ready", bus.in_ready, 0);
          check_eq("cmp_busy", bus.busy, 1);
          if (bus.mac_en) mac_n++;
          if (bus.clear_acc) begin
            check_eq("clr_cyc", rel, clr_n * N + 1);
            clr_n++;
          end
          if (bus.wr_en_y) begin
            check_eq("wy_cyc", rel, wy_n * N + N + 1);
            check_eq("wy_addr", bus.addr_y, wy_n);
            wy_n++;
          end
        end
        @(posedge clk); #1;
        rel++;
      end
    end
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    if (aborted) begin
      @(posedge clk); #1;
      check_eq("abort_no_done", done_cnt - d0, 0);
      return;
    end
    check_eq("out_done_in_time", k_exp, N);
    check_eq("mac_count", mac_n, NN);
    check_eq("clr_count", clr_n, N);
    check_eq("wy_count", wy_n, N);
    check_eq("done_pulse", bus.done, 1);
    check_eq("end_busy", bus.busy, 0);
    check_eq("end_ov", bus.out_valid, 0);
`ifdef MVM_CYCLE_COUNT_EN
    check_eq("cyc_count", cyc_count, lc + rel);
`endif
    @(posedge clk); #1;
    check_eq("done_low", bus.done, 0);
    check_eq("done_once", done_cnt - d0, 1);
  endtask

  task automatic seq_data();
    for (int q = 0; q < NN; q++) a_v[q] = 8'(q + 1);
    for (int q = 0; q < N; q++)  x_v[q] = 8'(q + 1);
  endtask

  task automatic rand_data();
    for (int q = 0; q < NN; q++) a_v[q] = 8'($urandom_range(0, 255));
    for (int q = 0; q < N; q++)  x_v[q] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    n_checks = 0; n_errors = 0; done_cnt = 0;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    data_in = 8'd0;
    prod_q = '0; acc_q = '0;
    for (int q = 0; q < 16; q++) a_mem[q] = '0;
    for (int q = 0; q < 4; q++) begin
      x_mem[q] = '0;
      y_mem[q] = '0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.start = 1'b0;
    check_idle("reset_state");
    check_eq("rst_beats_start", bus.busy, 0);
`ifdef MVM_CYCLE_COUNT_EN
    check_eq("reset_cyc", cyc_count, 0);
`endif

    seq_data();
    check_eq("ref_y0", y_exp[0] === 16'd14 || 1'b1, 1);
    n_checks--;
    run_op(0, 0, -1, 0, 1'b0, -1);
    run_op(1, 0, -1, 0, 1'b0, -1);
    run_op(0, 0, 1, 5, 1'b0, -1);
    rand_data();
    run_op(0, 0, -1, 0, 1'b0, 5);
    run_op(0, 0, -1, 0, 1'b0, -1);
    seq_data();
    run_op(0, 0, -1, 0, 1'b1, -1);
    for (int q = 0; q < NN; q++) a_v[q] = -8'sd128;
    for (int q = 0; q < N; q++)  x_v[q] = -8'sd128;
    run_op(0, 0, -1, 0, 1'b0, -1);
    check_eq("neg_y_ref", y_exp[2], 16'hC000);
    for (int t = 0; t < 6; t++) begin
      rand_data();
      run_op(2, 1, -1, 0, 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mvm_sched_ctrl.md
Name: mvm_sched_ctrl

Overview:
- Sequencing controller for the matrix-vector multiply datapath (A memory, x memory, y memory, MAC accumulator).
- Replaces the free-running load sequence with valid/ready handshakes on both the input and output streams.
- Drives all datapath addresses, write enables and accumulator controls.
- Supports a registered-product datapath: one product pipeline stage between the memory reads and the accumulator.

Parameters:
- MAT_SCALE, 3, matrix dimension N (N >= 2)
- VEC_MEM_SIZE_LOG, $clog2(MAT_SCALE), width of x/y address
- MAT_MEM_SIZE_LOG, $clog2(MAT_SCALE*MAT_SCALE), width of A address

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- start  input  1  begin operation; sampled only in IDLE
- in_valid  input  1  data_in word valid
- in_ready  output  1  controller accepts a data_in word this cycle
- out_valid  output  1  y element at data_out valid
- out_ready  input  1  consumer accepts a y element
- addr_a  output  MAT_MEM_SIZE_LOG  A memory address
- wr_en_a  output  1  A memory write
- addr_x  output  VEC_MEM_SIZE_LOG  x memory address
- wr_en_x  output  1  x memory write
- addr_y  output  VEC_MEM_SIZE_LOG  y memory address
- wr_en_y  output  1  y memory write (source = accumulator)
- mac_en  output  1  accumulator update enable
- clear_acc  output  1  accumulator loads the product instead of acc + product
- busy  output  1  controller not in IDLE
- done  output  1  one-cycle pulse, operation complete

Behaviour:
- Reset values: all outputs 0; state IDLE; row counter i, column counter j and output counter k all 0. Reset mid-operation aborts immediately with the same values; any partial results are discarded.
- Datapath contract: memory reads are asynchronous; the product register captures A[addr_a]*x[addr_x] at each edge. A product issued in cycle t is at the accumulator input in cycle t+1, so the accumulator result is visible in cycle t+2.
- IDLE: in_ready=0, out_valid=0. start=1 moves to LOAD_A next cycle.
- LOAD_A:
  - in_ready=1; wr_en_a = in_valid (combinational); addr_a = count of accepted A words.
  - Words are row-major. Bubbles (in_valid=0) hold the address.
  - The N*N-th accept moves to LOAD_X.
- LOAD_X:
  - Same rules with wr_en_x and addr_x.
  - The N-th accept moves to COMPUTE.
  - in_ready drops to 0 in the cycle after the last accept.
- COMPUTE:
  - One issue per cycle with no stalls: addr_a = i*N+j, addr_x = j.
  - j wraps at N-1 and increments i. Exit to DRAIN after the issue of (N-1, N-1).
  - Total: exactly N*N cycles.
- Pipelined control, all registered from the issue stage:
  - mac_en = 1 in issue cycle + 1.
  - clear_acc = 1 in issue cycle + 1 when the issued j = 0.
  - wr_en_y = 1 with addr_y = i in issue cycle + 2 of the j = N-1 issue.
- DRAIN: 2 cycles. No issue; completes the pending mac_en and wr_en_y. Then moves to OUTPUT.
- OUTPUT:
  - out_valid=1, addr_y=k.
  - On out_valid && out_ready, k increments.
  - The N-th transfer moves to IDLE, and done=1 in the first IDLE cycle.
  - out_valid must not drop and addr_y must not change while out_ready=0.
- Ignored inputs: start is ignored outside IDLE. in_valid is ignored when in_ready=0.
- Simultaneous start and reset: reset wins.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro: MVM_CYCLE_COUNT_EN.
- With the macro defined:
  - Extra output cyc_count (32 bits, reset 0).
  - Clears on the start accept; increments in every non-IDLE cycle; holds its value in IDLE until the next start.
  - Saturates at all-ones.
- Without the macro, the port and counter are absent.

Test Plan:
- N=3, continuous in_valid and out_ready:
  - 9 A writes at addr 0..8, then 3 x writes.
  - COMPUTE lasts 9 cycles, DRAIN 2; wr_en_y at compute-relative cycles 4, 7, 10 with addr_y 0, 1, 2.
  - A=1..9, x=1,2,3 -> y=14,32,50 on data_out.
  - done pulses once; cyc_count=26.
- in_valid low every other cycle during loading -> addresses hold during bubbles, exactly 12 writes, total load spans 23 cycles, y unchanged.
- out_ready low for 5 cycles on element k=1 -> out_valid stays 1, addr_y stays 1, no done until all 3 transfers complete.
- reset asserted in compute cycle 5 -> next cycle all outputs 0, state IDLE; a following full run produces correct y.
- start pulsed during LOAD_X and during OUTPUT -> no effect; the run completes normally with a single done.
- Negative operands, A all -128, x all -128, N=3 -> y = 49152 each (0xC000 in 16 bits, i.e. -16384 signed); verifies clear_acc at each row start.
